// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, reset/bubble constants, PC helpers.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Instruction addresses are word aligned; low two bits of any redirect are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, PC} holding buffer for a response that lands while decode is stalled.
module fetch_skid_buf
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        skid_valid,
  output logic [31:0] skid_instr,
  output logic [31:0] skid_pc
);

  logic        vld_p0;
  logic [31:0] instr_p0;
  logic [31:0] pc_p0;

  // Occupancy flag: clear wins, then load, then drain.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vld_p0 <= 1'b0;
    end else if (load) begin
      vld_p0 <= 1'b1;
    end else if (drain) begin
      vld_p0 <= 1'b0;
    end
  end

  // Payload capture; contents are meaningless while the flag is low.
  always_ff @(posedge clk) begin
    if (load) begin
      instr_p0 <= load_instr;
      pc_p0    <= load_pc;
    end
  end

  assign skid_valid = vld_p0;
  assign skid_instr = instr_p0;
  assign skid_pc    = pc_p0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding imem request FSM, IF/ID slot with skid.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCsrc,
  input  logic [31:0] target_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;

  logic [31:0]  instr_p1;
  logic [31:0]  pc_p1;
  logic         vld_p1;

  logic         skid_valid;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;

  logic         gnt_ok;
  logic         rsp_live;
  logic         slot_open;
  logic         kill;
  logic         skid_load;
  logic         skid_drain;

  // A request is only offered when the skid is empty, so a response and a
  // skid entry can never both be pending.
  assign imem_req   = (state_q == REQ) && !skid_valid;
  assign imem_addr  = pc_q;
  assign gnt_ok     = imem_req && imem_gnt;
  // Only a response in WAIT is current; responses seen in DROP/IDLE/REQ are stale.
  assign rsp_live   = (state_q == WAIT) && imem_rvalid;
  // Slot can take a new entry when it is empty or decode consumes it this cycle.
  assign slot_open  = !stall || !vld_p1;
  assign kill       = PCsrc || flush;
  assign skid_load  = rsp_live && !kill && !slot_open;
  assign skid_drain = skid_valid && slot_open && !kill;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (kill),
    .load_instr (imem_rdata),
    .load_pc    (pc_q),
    .skid_valid (skid_valid),
    .skid_instr (skid_instr),
    .skid_pc    (skid_pc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a redirect that leaves a response in flight parks in DROP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (gnt_ok) begin
          state_d = PCsrc ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
        end else if (PCsrc) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch PC: redirect wins, otherwise advance once per accepted response (wraps at 2^32).
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (PCsrc) begin
      pc_q <= align_pc(target_pc);
    end else if (rsp_live) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // IF/ID valid: kill empties it; otherwise refill from skid first, then the live response.
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      vld_p1 <= 1'b0;
    end else if (slot_open) begin
      vld_p1 <= skid_valid || rsp_live;
    end
  end

  // ---- IF/ID stage boundary: word and its issuing PC captured together ----
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_p1 <= NOP_INSTR;
      pc_p1    <= RESET_PC;
    end else if (!kill && slot_open) begin
      if (skid_valid) begin
        instr_p1 <= skid_instr;
        pc_p1    <= skid_pc;
      end else if (rsp_live) begin
        instr_p1 <= imem_rdata;
        pc_p1    <= pc_q;
      end
    end
  end

  assign instr       = vld_p1 ? instr_p1 : NOP_INSTR;
  assign instr_valid = vld_p1;
  assign PC          = pc_p1;
  assign PC_plus4    = pc_p1 + 32'd4;

endmodule
